// File: rtl/game_pkg.sv
// Shared constants and types for the reaction-game display path.
// Holds the block position range, the direction encoding and the default shift rates.
package game_pkg;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_e;

   localparam logic [3:0] POS_MIN = 4'd0;
   localparam logic [3:0] POS_MAX = 4'd9;

   localparam int DEF_LIMIT0 = 49_999_999;
   localparam int DEF_LIMIT1 = 24_999_999;
   localparam int DEF_LIMIT2 = 12_499_999;
   localparam int DEF_LIMIT3 = 6_249_999;
   localparam int DEF_CW     = 26;

   // One-hot image of a block index; indices past the board light nothing.
   function automatic logic [9:0] onehot10(input logic [3:0] p);
      logic [9:0] img;
      img = 10'd0;
      if (p <= POS_MAX) begin
         img = 10'b00_0000_0001 << p;
      end else begin
         img = 10'd0;
      end
      return img;
   endfunction

endpackage

// File: rtl/block_mover_shift_tick.sv
// Divide-down counter producing block shift events at one of four rates.
// The >= compare keeps a speed-up from wrapping the counter all the way around.
module shift_tick
   import game_pkg::*;
#(
   parameter int LIMIT0 = DEF_LIMIT0,
   parameter int LIMIT1 = DEF_LIMIT1,
   parameter int LIMIT2 = DEF_LIMIT2,
   parameter int LIMIT3 = DEF_LIMIT3,
   parameter int CW     = DEF_CW
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] speed,
   input  logic       run,
   output logic       tick
);

   logic [1:0]    speed_q_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] limit_s;
   logic          at_limit_s;

   // Speed code register; one cycle of latency from the selector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_q_r <= 2'b00;
      end else begin
         speed_q_r <= speed;
      end
   end

   // Terminal count selected by the registered speed code.
   always_comb begin
      limit_s = CW'(LIMIT0);
      case (speed_q_r)
         2'b00:   limit_s = CW'(LIMIT0);
         2'b01:   limit_s = CW'(LIMIT1);
         2'b10:   limit_s = CW'(LIMIT2);
         2'b11:   limit_s = CW'(LIMIT3);
         default: limit_s = CW'(LIMIT0);
      endcase
   end

   assign at_limit_s = (count_r >= limit_s);
   assign tick       = run & at_limit_s;

   // Counter holds while frozen so a suppressed shift fires as soon as run returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
      end else if (run) begin
         if (at_limit_s) begin
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/block_mover.sv
// Bouncing single-LED block across LEDR[9:0], advanced by shift_tick events.
// All outputs are registered; LEDR is decoded from the next position so it tracks pos.
module block_mover
   import game_pkg::*;
#(
   parameter int LIMIT0 = DEF_LIMIT0,
   parameter int LIMIT1 = DEF_LIMIT1,
   parameter int LIMIT2 = DEF_LIMIT2,
   parameter int LIMIT3 = DEF_LIMIT3,
   parameter int CW     = DEF_CW
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [1:0] speed,
   input  logic       run,
   output logic [9:0] LEDR,
   output logic [3:0] pos,
   output logic       dir,
   output logic       shift
);

   dir_e       state_r;
   logic [3:0] pos_r;
   logic [9:0] ledr_r;
   logic       shift_r;
   logic       tick_s;

   shift_tick #(
      .LIMIT0 (LIMIT0),
      .LIMIT1 (LIMIT1),
      .LIMIT2 (LIMIT2),
      .LIMIT3 (LIMIT3),
      .CW     (CW)
   ) u_shift_tick (
      .clk   (Clock),
      .rst_n (Resetn),
      .speed (speed),
      .run   (run),
      .tick  (tick_s)
   );

   // Direction state machine; end cells turn the block around on the following shift.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r <= RIGHT;
         pos_r   <= POS_MIN;
         ledr_r  <= onehot10(POS_MIN);
         shift_r <= 1'b0;
      end else begin
         shift_r <= tick_s;
         if (tick_s) begin
            case (state_r)
               RIGHT: begin
                  if (pos_r >= POS_MAX) begin
                     state_r <= LEFT;
                     pos_r   <= POS_MAX - 4'd1;
                     ledr_r  <= onehot10(POS_MAX - 4'd1);
                  end else begin
                     state_r <= RIGHT;
                     pos_r   <= pos_r + 4'd1;
                     ledr_r  <= onehot10(pos_r + 4'd1);
                  end
               end
               LEFT: begin
                  if (pos_r <= POS_MIN) begin
                     state_r <= RIGHT;
                     pos_r   <= POS_MIN + 4'd1;
                     ledr_r  <= onehot10(POS_MIN + 4'd1);
                  end else begin
                     state_r <= LEFT;
                     pos_r   <= pos_r - 4'd1;
                     ledr_r  <= onehot10(pos_r - 4'd1);
                  end
               end
               default: begin
                  state_r <= RIGHT;
                  pos_r   <= POS_MIN;
                  ledr_r  <= onehot10(POS_MIN);
               end
            endcase
         end else begin
            state_r <= state_r;
            pos_r   <= pos_r;
            ledr_r  <= ledr_r;
         end
      end
   end

   assign LEDR  = ledr_r;
   assign pos   = pos_r;
   assign dir   = (state_r == RIGHT);
   assign shift = shift_r;

endmodule
